// File: rtl/decimal_accumulator.sv
// Decimal-to-binary accumulator: folds an MSD-first BCD digit stream into a
// saturating 13-bit binary value using a three-state shift-and-add sequence.
`timescale 1ns/1ps
module decimal_accumulator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic        digit_ready,
  input  logic        commit,
  output logic [12:0] value,
  output logic        value_valid,
  output logic        overflow,
  output logic        digit_error
);

  localparam int unsigned ACC_W = 13;
  localparam int unsigned TMP_W = 17;
  localparam int unsigned DIG_W = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TIMES8  = 2'd1;
  localparam logic [1:0] TIMES10 = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(9);

  logic [1:0]       state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [TMP_W-1:0] tmp, tmp_next;
  logic [DIG_W-1:0] digit_q, digit_next;
  logic             value_valid_next, overflow_next, digit_error_next;
  logic [TMP_W-1:0] sum;

  assign value       = acc;
  assign digit_ready = (state == IDLE) && !commit && !clear;
  assign sum         = tmp + (TMP_W'(acc) << 1);

  // Next-state and datapath update; clear overrides everything.
  always_comb begin
    state_next       = state;
    acc_next         = acc;
    tmp_next         = tmp;
    digit_next       = digit_q;
    value_valid_next = 1'b0;
    overflow_next    = overflow;
    digit_error_next = digit_error;
    if (clear) begin
      state_next       = IDLE;
      acc_next         = '0;
      tmp_next         = '0;
      digit_next       = '0;
      overflow_next    = 1'b0;
      digit_error_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (commit) begin
            value_valid_next = 1'b1;
          end else if (digit_valid) begin
            if (digit > DIG_MAX) begin
              digit_error_next = 1'b1;
            end else begin
              digit_next = digit;
              state_next = TIMES8;
            end
          end
        end
        TIMES8: begin
          tmp_next   = (TMP_W'(acc) << 3) + TMP_W'(digit_q);
          state_next = TIMES10;
        end
        TIMES10: begin
          state_next = IDLE;
          // Once saturated, stay pinned at the maximum.
          if (overflow || (sum > TMP_W'(ACC_MAX))) begin
            acc_next      = ACC_MAX;
            overflow_next = 1'b1;
          end else begin
            acc_next = sum[ACC_W-1:0];
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      tmp         <= '0;
      digit_q     <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
      digit_error <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      tmp         <= tmp_next;
      digit_q     <= digit_next;
      value_valid <= value_valid_next;
      overflow    <= overflow_next;
      digit_error <= digit_error_next;
    end
  end

endmodule

// File: tb/tb_decimal_accumulator.sv
// Self-checking bench for decimal_accumulator: digit-string vector table,
// committed values checked through a scoreboard queue, plus corner sequences.
`timescale 1ns/1ps
module tb_decimal_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        commit = 1'b0;
  logic        digit_ready;
  logic [12:0] value;
  logic        value_valid;
  logic        overflow;
  logic        digit_error;

  int total = 0;
  int bad   = 0;
  logic [12:0] expq[$];

  typedef struct {
    logic [19:0] digs;
    int          n;
    logic [12:0] val;
    logic        ovf;
  } vec_t;
  vec_t vecs[7];

  decimal_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .digit_valid(digit_valid),
    .digit(digit), .digit_ready(digit_ready), .commit(commit), .value(value),
    .value_valid(value_valid), .overflow(overflow), .digit_error(digit_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every value_valid pulse must match a queued commit.
  always @(negedge clk) begin
    if (rst_n && value_valid) begin
      if (expq.size() == 0) check("spurious_value_valid", 32'(value_valid), 32'd0);
      else check("committed_value", 32'(value), 32'(expq.pop_front()));
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!digit_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!digit_ready) check("ready_timeout", 32'(digit_ready), 32'd1);
  endtask

  task automatic send_digit(input logic [3:0] d);
    wait_ready();
    digit_valid = 1'b1;
    digit = d;
    @(posedge clk);
    #1 digit_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [12:0] exp);
    wait_ready();
    commit = 1'b1;
    expq.push_back(exp);
    @(posedge clk);
    #1 commit = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] dg;
    logic [5:0]  pat;

    vecs[0] = '{20'h12340, 4, 13'd1234, 1'b0};
    vecs[1] = '{20'h81910, 4, 13'd8191, 1'b0};
    vecs[2] = '{20'h81920, 4, 13'd8191, 1'b1};
    vecs[3] = '{20'h99999, 5, 13'd8191, 1'b1};
    vecs[4] = '{20'h00000, 1, 13'd0,    1'b0};
    vecs[5] = '{20'h70500, 3, 13'd705,  1'b0};
    vecs[6] = '{20'h00090, 4, 13'd9,    1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", 32'(value), 32'd0);
    check("rst_value_valid", 32'(value_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_digit_error", 32'(digit_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(digit_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      do_clear();
      dg = vecs[i].digs;
      for (int k = 0; k < vecs[i].n; k++) send_digit(dg[19-4*k -: 4]);
      do_commit(vecs[i].val);
      @(negedge clk);
      check("vec_overflow", 32'(overflow), 32'(vecs[i].ovf));
      check("vec_digit_error", 32'(digit_error), 32'd0);
    end

    // Illegal digit after 7, then 3
    do_clear();
    send_digit(4'd7);
    send_digit(4'hA);
    @(negedge clk);
    check("err_flag", 32'(digit_error), 32'd1);
    check("err_value", 32'(value), 32'd7);
    check("err_ready", 32'(digit_ready), 32'd1);
    send_digit(4'd3);
    do_commit(13'd73);
    @(negedge clk);
    check("err_sticky", 32'(digit_error), 32'd1);

    // Continuous digit_valid with 5,5
    do_clear();
    wait_ready();
    digit_valid = 1'b1;
    digit = 4'd5;
    pat = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      check("ready_pattern", 32'(digit_ready), 32'(pat[5-i]));
      if (i == 5) digit_valid = 1'b0;
      @(negedge clk);
    end
    check("hold_value", 32'(value), 32'd55);
    commit = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd5;
    expq.push_back(13'd55);
    @(posedge clk);
    #1 commit = 1'b0;
    digit_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("commit_wins_value", 32'(value), 32'd55);

    // Commit while busy is ignored
    do_clear();
    send_digit(4'd4);
    commit = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 commit = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_commit_value", 32'(value), 32'd4);
    do_commit(13'd4);

    // Clear at the TIMES8 edge of digit 9 after 12
    do_clear();
    send_digit(4'hF);
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd9);
    @(negedge clk);
    check("times8_value_stable", 32'(value), 32'd12);
    check("times8_ready", 32'(digit_ready), 32'd0);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clear_value", 32'(value), 32'd0);
    check("clear_ready", 32'(digit_ready), 32'd1);
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_digit_error", 32'(digit_error), 32'd0);
    repeat (3) @(negedge clk);
    check("clear_discard", 32'(value), 32'd0);
    do_commit(13'd0);

    // Async reset during TIMES10
    do_clear();
    send_digit(4'hB);
    for (int k = 0; k < 4; k++) send_digit(4'd9);
    send_digit(4'd5);
    @(posedge clk);
    #1;
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    check("pre_rst_value", 32'(value), 32'd8191);
    #1 rst_n = 1'b0;
    #1;
    check("async_value", 32'(value), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_digit_error", 32'(digit_error), 32'd0);
    check("async_value_valid", 32'(value_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_value", 32'(value), 32'd0);
    check("post_rst_ready", 32'(digit_ready), 32'd1);
    do_commit(13'd0);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
